// File: rtl/jtag_scan_master_if.sv
// Command/response bus of the JTAG scan master.
// Latency: none, wires only.
// Backpressure: a command is taken when cmd_valid && cmd_ready; responses cannot be stalled.
//
// Signals:
//   cmd_valid / cmd_ready  command handshake (cmd_ready high means the master is idle)
//   cmd_type               00 TAP reset, 01 IR scan, 10 DR scan, 11 idle clocks
//   cmd_len                shift length or idle count (0 means 1, >32 means 32)
//   cmd_data               TDI bits, shifted LSB-first
//   rsp_valid              one-cycle completion pulse
//   rsp_data               captured TDO bits, stable until the next rsp_valid
//   busy                   inverse of cmd_ready
interface jtag_scan_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;

    // Requester side (software / sequencer).
    modport master (
        output cmd_valid, cmd_type, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    // Scan master side.
    modport slave (
        input  cmd_valid, cmd_type, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/jtag_scan_master.sv
// JTAG scan master: runs TAP reset, IR scan, DR scan and idle-clock commands on the TCK/TMS/TDI/TDO pins.
// Latency: 2*TCK_DIV*N clk cycles from acceptance to rsp_valid, N = number of TCKs of the command.
// Backpressure: cmd_ready is low for the whole command; a new command may be taken in the rsp_valid cycle.
//
// Ports:
//   clk, reset_n            system clock, asynchronous active-low reset
//   bus (slave modport)     command/response handshake, see jtag_scan_master_if
//   tck_o, tms_o, tdi_o     JTAG master pins
//   tdo_i                   JTAG TDO from the TAP
module jtag_scan_master #(
    parameter int TCK_DIV = 4,    // clk cycles per TCK half-period, 1..255
    parameter int MAX_LEN = 32    // maximum shift length in bits
) (
    input  logic                 clk,
    input  logic                 reset_n,
    jtag_scan_master_if.slave    bus,
    output logic                 tck_o,
    output logic                 tms_o,
    output logic                 tdi_o,
    input  logic                 tdo_i
);

    // Sequencer states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRE   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_POST  = 2'd3;

    // Command types.
    localparam logic [1:0] CMD_RESET = 2'd0;
    localparam logic [1:0] CMD_IR    = 2'd1;
    localparam logic [1:0] CMD_DR    = 2'd2;
    localparam logic [1:0] CMD_IDLE  = 2'd3;

    localparam logic [7:0] PH_LAST = 8'(TCK_DIV - 1);
    localparam logic [5:0] LEN_MAX = 6'(MAX_LEN);

    logic [1:0]  state_q, state_d;
    logic [7:0]  ph_q, ph_d;        // clk edges within the current TCK half-period
    logic [5:0]  bit_q, bit_d;      // TCK index within the current state
    logic        tck_q, tck_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;
    logic [1:0]  typ_q, typ_d;
    logic [5:0]  len_q, len_d;      // effective length, 1..32
    logic [31:0] data_q, data_d;
    logic [31:0] cap_q, cap_d;      // TDO bits of the running command
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_vld_q, rsp_vld_d;

    logic [5:0]  eff_len;
    logic        accept;
    logic        last_in_state;
    logic        cmd_done;
    logic [1:0]  nxt_state;
    logic [5:0]  nxt_bit;

    // Number of TCKs spent in PRE. Reset and idle commands run entirely in PRE.
    function automatic logic [5:0] pre_len(input logic [1:0] typ, input logic [5:0] len);
        logic [5:0] r;
        case (typ)
            CMD_RESET: r = 6'd6;
            CMD_IR:    r = 6'd4;
            CMD_DR:    r = 6'd3;
            default:   r = len;
        endcase
        return r;
    endfunction

    // TMS/TDI values for TCK 'cnt' of state 'st'. Packed as {tms, tdi}.
    function automatic logic [1:0] pins(input logic [1:0]  st,
                                        input logic [5:0]  cnt,
                                        input logic [1:0]  typ,
                                        input logic [5:0]  len,
                                        input logic [31:0] data);
        logic tms;
        logic tdi;
        tms = 1'b0;
        tdi = 1'b0;
        case (st)
            ST_PRE: begin
                case (typ)
                    CMD_RESET: tms = (cnt < 6'd5);   // 1,1,1,1,1,0
                    CMD_IR:    tms = (cnt < 6'd2);   // 1,1,0,0
                    CMD_DR:    tms = (cnt == 6'd0);  // 1,0,0
                    default:   tms = 1'b0;           // idle clocks
                endcase
            end
            ST_SHIFT: begin
                // TMS goes high on the last shift bit to leave Shift-xR.
                tms = (cnt == len - 6'd1);
                tdi = data[cnt[4:0]];
            end
            ST_POST: tms = (cnt == 6'd0);            // 1,0 back to Run-Test/Idle
            default: ;
        endcase
        return {tms, tdi};
    endfunction

    always_comb begin
        if (bus.cmd_len == 6'd0) begin
            eff_len = 6'd1;
        end else if (bus.cmd_len > LEN_MAX) begin
            eff_len = LEN_MAX;
        end else begin
            eff_len = bus.cmd_len;
        end
    end

    assign accept = (state_q == ST_IDLE) && bus.cmd_valid;

    // Where the sequencer goes after the current TCK finishes.
    always_comb begin
        last_in_state = 1'b0;
        cmd_done      = 1'b0;
        nxt_state     = state_q;
        nxt_bit       = bit_q + 6'd1;
        case (state_q)
            ST_PRE: begin
                last_in_state = (bit_q == pre_len(typ_q, len_q) - 6'd1);
                if (last_in_state) begin
                    if (typ_q == CMD_IR || typ_q == CMD_DR) begin
                        nxt_state = ST_SHIFT;
                        nxt_bit   = 6'd0;
                    end else begin
                        cmd_done = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                last_in_state = (bit_q == len_q - 6'd1);
                if (last_in_state) begin
                    nxt_state = ST_POST;
                    nxt_bit   = 6'd0;
                end
            end
            ST_POST: begin
                last_in_state = (bit_q == 6'd1);
                cmd_done      = last_in_state;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        bit_d      = bit_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        typ_d      = typ_q;
        len_d      = len_q;
        data_d     = data_q;
        cap_d      = cap_q;
        rsp_data_d = rsp_data_q;
        rsp_vld_d  = 1'b0;

        if (accept) begin
            // The accepting edge is also the "TCK low" edge of bit 0.
            typ_d          = bus.cmd_type;
            len_d          = eff_len;
            data_d         = bus.cmd_data;
            cap_d          = '0;
            state_d        = ST_PRE;
            bit_d          = 6'd0;
            ph_d           = 8'd0;
            {tms_d, tdi_d} = pins(ST_PRE, 6'd0, bus.cmd_type, eff_len, bus.cmd_data);
        end else if (state_q != ST_IDLE) begin
            if (ph_q == PH_LAST) begin
                ph_d = 8'd0;
                if (!tck_q) begin
                    tck_d = 1'b1;
                    if (state_q == ST_SHIFT) begin
                        cap_d[bit_q[4:0]] = tdo_i;
                    end
                end else begin
                    tck_d = 1'b0;
                    if (cmd_done) begin
                        // TMS/TDI are left as they are: every sequence ends with TMS=0 outside shift.
                        state_d    = ST_IDLE;
                        bit_d      = 6'd0;
                        rsp_vld_d  = 1'b1;
                        rsp_data_d = cap_q;
                    end else begin
                        state_d        = nxt_state;
                        bit_d          = nxt_bit;
                        {tms_d, tdi_d} = pins(nxt_state, nxt_bit, typ_q, len_q, data_q);
                    end
                end
            end else begin
                ph_d = ph_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ph_q       <= 8'd0;
            bit_q      <= 6'd0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            typ_q      <= 2'd0;
            len_q      <= 6'd0;
            data_q     <= '0;
            cap_q      <= '0;
            rsp_data_q <= '0;
            rsp_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            bit_q      <= bit_d;
            tck_q      <= tck_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            typ_q      <= typ_d;
            len_q      <= len_d;
            data_q     <= data_d;
            cap_q      <= cap_d;
            rsp_data_q <= rsp_data_d;
            rsp_vld_q  <= rsp_vld_d;
        end
    end

    assign tck_o         = tck_q;
    assign tms_o         = tms_q;
    assign tdi_o         = tdi_q;
    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Testbench for jtag_scan_master with TCK_DIV=2.
// Directed vector table, randomized commands against a pin-level reference model,
// back-to-back and mid-command reset sequences.
module tb_jtag_scan_master;

    localparam int D = 2;

    typedef struct {
        logic [1:0]  typ;
        logic [5:0]  len;
        logic [31:0] data;
        bit          tie;      // TDO looped back from TDI
        logic [63:0] pat;      // TDO value per TCK index when not looped back
        int          ntck;
        int          cycles;
        logic [63:0] tms;      // TMS per TCK index
        logic [31:0] rsp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tck_o, tms_o, tdi_o;
    wire         tdo_i;
    bit          tdo_tie;
    logic [63:0] tdo_pat;
    logic [5:0]  rise_idx;
    logic [31:0] prev_rsp;

    int n_chk  = 0;
    int n_fail = 0;

    jtag_scan_master_if bus();

    jtag_scan_master #(.TCK_DIV(D), .MAX_LEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .tck_o   (tck_o),
        .tms_o   (tms_o),
        .tdi_o   (tdi_o),
        .tdo_i   (tdo_i)
    );

    always #5 clk = ~clk;

    assign tdo_i = tdo_tie ? tdi_o : tdo_pat[rise_idx];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference model: pin sequence per TCK index, built from the command rules.
    function automatic void model(input logic [1:0] typ, input logic [5:0] len,
                                  input logic [31:0] data, input bit tie, input logic [63:0] pat,
                                  output int ntck, output logic [63:0] tms,
                                  output logic [63:0] tdi, output logic [31:0] rsp);
        int n;
        int pre;
        n   = (len == 0) ? 1 : ((len > 32) ? 32 : int'(len));
        tms = '0;
        tdi = '0;
        rsp = '0;
        case (typ)
            2'd0: begin ntck = 6; tms = 64'h1F; end
            2'd3: begin ntck = n; end
            default: begin
                pre  = (typ == 2'd1) ? 4 : 3;
                tms  = (typ == 2'd1) ? 64'h3 : 64'h1;
                ntck = pre + n + 2;
                for (int i = 0; i < n; i++) begin
                    tdi[pre+i] = data[i];
                    rsp[i]     = tie ? data[i] : pat[pre+i];
                end
                tms[pre+n-1] = 1'b1;
                tms[pre+n]   = 1'b1;
            end
        endcase
    endfunction

    task automatic apply(input vec_t v, input string nm);
        int          m_n, nr, c, w;
        logic [63:0] m_tms, m_tdi, g_tms, g_tdi;
        logic [31:0] m_rsp;
        bit          prev_tck, timing_ok, stable_ok, seen;
        model(v.typ, v.len, v.data, v.tie, v.pat, m_n, m_tms, m_tdi, m_rsp);
        w = 0;
        while (!bus.cmd_ready && w < 400) begin @(negedge clk); w++; end
        chk({nm, " ready_before"}, 64'(bus.cmd_ready), 64'd1);
        tdo_tie  = v.tie;
        tdo_pat  = v.pat;
        rise_idx = 6'd0;
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = v.typ;
        bus.cmd_len   = v.len;
        bus.cmd_data  = v.data;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        g_tms = '0; g_tdi = '0; nr = 0; c = 0;
        prev_tck = 1'b0; timing_ok = 1'b1; stable_ok = 1'b1; seen = 1'b0;
        while (c < 400) begin
            if (tck_o && !prev_tck) begin
                if (nr < 64) begin
                    g_tms[nr] = tms_o;
                    g_tdi[nr] = tdi_o;
                end
                if (c != D + 2*D*nr) timing_ok = 1'b0;
                nr++;
                rise_idx = 6'(nr);
            end
            prev_tck = tck_o;
            if (bus.rsp_valid) begin seen = 1'b1; break; end
            if (bus.rsp_data !== prev_rsp) stable_ok = 1'b0;
            @(negedge clk);
            c++;
        end
        chk({nm, " rsp_seen"},   64'(seen), 64'd1);
        chk({nm, " rsp_cycle"},  64'(c), 64'(v.cycles));
        chk({nm, " tck_count"},  64'(nr), 64'(v.ntck));
        chk({nm, " tms_seq"},    g_tms, v.tms);
        chk({nm, " tdi_seq"},    g_tdi, m_tdi);
        chk({nm, " rsp_data"},   64'(bus.rsp_data), 64'(v.rsp));
        chk({nm, " ready_done"}, 64'({bus.cmd_ready, bus.busy}), 64'b10);
        chk({nm, " tck_timing"}, 64'(timing_ok), 64'd1);
        chk({nm, " rsp_stable"}, 64'(stable_ok), 64'd1);
        @(negedge clk);
        chk({nm, " pulse_end"},  64'({bus.rsp_valid, tck_o, tms_o}), 64'b000);
        prev_rsp = v.rsp;
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        int          acc, nrsp, nr, c;
        int          acc_c[2];
        int          rsp_c[2];
        logic [63:0] g_tms;
        bit          prev_tck, ok;

        //            typ    len   data           tie  pat      ntck cyc  tms                     rsp
        tbl[0] = '{2'd0, 6'd0,  32'h0,        1'b0, 64'h0,   6,   24,  64'h1F,                 32'h0};
        tbl[1] = '{2'd1, 6'd5,  32'h11,       1'b0, 64'h160, 11,  44,  64'h303,                32'h16};
        tbl[2] = '{2'd2, 6'd32, 32'hDEADBEEF, 1'b1, 64'h0,   37,  148, 64'h0000_000C_0000_0001, 32'hDEADBEEF};
        tbl[3] = '{2'd2, 6'd0,  32'h1,        1'b1, 64'h0,   6,   24,  64'h19,                 32'h1};
        tbl[4] = '{2'd2, 6'd40, 32'h12345678, 1'b1, 64'h0,   37,  148, 64'h0000_000C_0000_0001, 32'h12345678};
        tbl[5] = '{2'd3, 6'd3,  32'hFFFFFFFF, 1'b0, 64'h0,   3,   12,  64'h0,                  32'h0};

        reset_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_type = 2'd0; bus.cmd_len = 6'd0; bus.cmd_data = '0;
        tdo_tie = 1'b0; tdo_pat = '0; rise_idx = 6'd0; prev_rsp = '0;
        repeat (3) @(negedge clk);
        chk("reset_pins", 64'({tck_o, tms_o, tdi_o}), 64'b010);
        chk("reset_bus",  64'({bus.cmd_ready, bus.busy, bus.rsp_valid}), 64'b100);
        chk("reset_rsp",  64'(bus.rsp_data), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) apply(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            rv.typ  = 2'($urandom_range(0, 3));
            rv.len  = 6'($urandom_range(0, 40));
            rv.data = $urandom;
            rv.tie  = 1'($urandom_range(0, 1));
            rv.pat  = {$urandom, $urandom};
            begin
                logic [63:0] dummy_tdi;
                model(rv.typ, rv.len, rv.data, rv.tie, rv.pat, rv.ntck, rv.tms, dummy_tdi, rv.rsp);
            end
            rv.cycles = 2 * D * rv.ntck;
            apply(rv, $sformatf("rand%0d", i));
        end

        // Back-to-back: idle(3) then reset, cmd_valid held high throughout.
        tdo_tie = 1'b0; tdo_pat = '0; rise_idx = 6'd0;
        bus.cmd_valid = 1'b1; bus.cmd_type = 2'd3; bus.cmd_len = 6'd3; bus.cmd_data = '0;
        acc = 0; nrsp = 0; nr = 0; c = 0; g_tms = '0; prev_tck = 1'b0;
        acc_c[0] = 0; acc_c[1] = 0; rsp_c[0] = 0; rsp_c[1] = 0;
        while (nrsp < 2 && c < 300) begin
            if (acc == 1 && c > acc_c[0]) begin bus.cmd_type = 2'd0; bus.cmd_len = 6'd0; end
            if (acc == 2 && c > acc_c[1]) bus.cmd_valid = 1'b0;
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (acc < 2) acc_c[acc] = c;
                acc++;
            end
            if (tck_o && !prev_tck) begin
                if (nr < 64) g_tms[nr] = tms_o;
                nr++;
            end
            prev_tck = tck_o;
            if (bus.rsp_valid) begin
                if (nrsp < 2) rsp_c[nrsp] = c;
                nrsp++;
            end
            @(negedge clk);
            c++;
        end
        bus.cmd_valid = 1'b0;
        chk("b2b_rsp_count", 64'(nrsp), 64'd2);
        chk("b2b_accepts",   64'(acc), 64'd2);
        chk("b2b_first_lat", 64'(rsp_c[0] - acc_c[0]), 64'(1 + 2*D*3));
        chk("b2b_same_cyc",  64'(acc_c[1]), 64'(rsp_c[0]));
        chk("b2b_second_lat",64'(rsp_c[1] - acc_c[1]), 64'(1 + 2*D*6));
        chk("b2b_tcks",      64'(nr), 64'd9);
        chk("b2b_tms",       g_tms, 64'hF8);
        prev_rsp = '0;
        @(negedge clk);

        // Reset during DR shift bit 10 (TCK index 13).
        tdo_tie = 1'b1;
        bus.cmd_valid = 1'b1; bus.cmd_type = 2'd2; bus.cmd_len = 6'd16; bus.cmd_data = $urandom;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        nr = 0; c = 0; prev_tck = 1'b0; ok = 1'b1;
        while (nr < 14 && c < 300) begin
            if (tck_o && !prev_tck) nr++;
            prev_tck = tck_o;
            if (bus.rsp_valid) ok = 1'b0;
            if (nr < 14) begin @(negedge clk); c++; end
        end
        chk("abort_reached_bit10", 64'(nr), 64'd14);
        chk("abort_no_early_rsp",  64'(ok), 64'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_pins", 64'({tck_o, tms_o, tdi_o}), 64'b010);
        chk("abort_bus",  64'({bus.cmd_ready, bus.busy, bus.rsp_valid}), 64'b100);
        chk("abort_rsp",  64'(bus.rsp_data), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.rsp_valid || !bus.cmd_ready || tck_o) ok = 1'b0;
        end
        chk("abort_quiet_after", 64'(ok), 64'd1);
        prev_rsp = '0;
        apply(tbl[0], "post_abort_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
